// File: rtl/instr_dispatch_fsm_pkg.sv
// Shared definitions for the instruction dispatcher: opcode map, opcode classes,
// FSM states, fault codes and instruction-word field offsets.
package instr_dispatch_fsm_pkg;

    localparam int OPC_W   = 4;
    localparam int PRM_W   = 6;
    localparam int OPC_LSB = 12;
    localparam int P1_LSB  = 6;
    localparam int P2_LSB  = 0;

    localparam logic [OPC_W-1:0] OPC_LDI  = 4'h8;
    localparam logic [OPC_W-1:0] OPC_MOV  = 4'h9;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LDI,
        CLS_MOV,
        CLS_JMP,
        CLS_HALT,
        CLS_ILL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_DECODE,
        ST_ACT,
        ST_WAIT,
        ST_HALT,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/instr_dispatch_fsm_opcode_classifier.sv
// Combinational opcode-to-class decode, shared with disassembly/trace monitors.
module opcode_classifier
    import instr_dispatch_fsm_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_e        op_class
);

    always_comb begin
        op_class = CLS_ILL;
        if (opcode[3] == 1'b0) begin
            op_class = CLS_ALU;
        end else begin
            case (opcode)
                OPC_LDI:  op_class = CLS_LDI;
                OPC_MOV:  op_class = CLS_MOV;
                OPC_JMP:  op_class = CLS_JMP;
                OPC_HALT: op_class = CLS_HALT;
                default:  op_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatch_fsm.sv
// Top-level instruction sequencer: fetch, decode, one-cycle activate of one
// execution unit, wait for its done with a watchdog, plus halt/fault handling.
module instr_dispatch_fsm
    import instr_dispatch_fsm_pkg::*;
#(
    parameter int IR_W    = 16,
    parameter int TIMEOUT = 32,
    parameter int TO_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IR_W-1:0]  irIn,
    input  logic             aluDone,
    input  logic             ldDone,
    input  logic             movDone,
    input  logic             jmpDone,
    output logic             pcOut,
    output logic             memRd,
    output logic             irLatch,
    output logic [OPC_W-1:0] opcode,
    output logic [PRM_W-1:0] param1,
    output logic [PRM_W-1:0] param2,
    output logic             aluAct,
    output logic             ldAct,
    output logic             movAct,
    output logic             jmpAct,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       faultCode
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WD_MAX  = {TO_W{1'b1}};

    state_e           state_reg, state_next;
    op_class_e        cls_reg, cls_next, cls_dec;
    logic [IR_W-1:0]  ir_reg, ir_next;
    logic [TO_W-1:0]  wd_reg, wd_next;
    logic [OPC_W-1:0] opcode_reg, opcode_next;
    logic [PRM_W-1:0] param1_reg, param1_next;
    logic [PRM_W-1:0] param2_reg, param2_next;
    logic [1:0]       fcode_reg, fcode_next;
    logic [3:0]       act_reg, act_next;
    logic [3:0]       done_vec;
    logic             sel_done;
    logic             pc_reg, pc_next;
    logic             rd_reg, rd_next;
    logic             latch_reg, latch_next;
    logic             busy_reg, busy_next;
    logic             halted_reg, halted_next;
    logic             fault_reg, fault_next;

    opcode_classifier u_classifier (
        .opcode   (ir_reg[OPC_LSB +: OPC_W]),
        .op_class (cls_dec)
    );

    // Unit index order matches op_class_e: ALU, LDI, MOV, JMP.
    assign done_vec = {jmpDone, movDone, ldDone, aluDone};

    always_comb begin
        sel_done = 1'b0;
        case (cls_reg)
            CLS_ALU: sel_done = done_vec[0];
            CLS_LDI: sel_done = done_vec[1];
            CLS_MOV: sel_done = done_vec[2];
            CLS_JMP: sel_done = done_vec[3];
            default: sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cls_next    = cls_reg;
        ir_next     = ir_reg;
        wd_next     = wd_reg;
        opcode_next = opcode_reg;
        param1_next = param1_reg;
        param2_next = param2_reg;
        fcode_next  = fcode_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_FETCH0;
            ST_FETCH0: state_next = ST_FETCH1;
            ST_FETCH1: begin
                ir_next    = irIn;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_next = ir_reg[OPC_LSB +: OPC_W];
                param1_next = ir_reg[P1_LSB +: PRM_W];
                param2_next = ir_reg[P2_LSB +: PRM_W];
                cls_next    = cls_dec;
                case (cls_dec)
                    CLS_HALT: state_next = ST_HALT;
                    CLS_ILL: begin
                        state_next = ST_FAULT;
                        fcode_next = FC_ILLEGAL;
                    end
                    default:  state_next = ST_ACT;
                endcase
            end
            // Done is deliberately not looked at here so a stale level is blanked.
            ST_ACT: begin
                wd_next    = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_done) begin
                    state_next = ST_FETCH0;
                end else if (wd_reg == WD_LAST) begin
                    state_next = ST_FAULT;
                    fcode_next = FC_TIMEOUT;
                end else if (wd_reg != WD_MAX) begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            default:   state_next = state_reg;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track state_reg exactly.
    always_comb begin
        pc_next     = (state_next == ST_FETCH0) || (state_next == ST_FETCH1);
        rd_next     = pc_next;
        latch_next  = (state_next == ST_FETCH1);
        busy_next   = (state_next != ST_IDLE) && (state_next != ST_HALT)
                      && (state_next != ST_FAULT);
        halted_next = (state_next == ST_HALT);
        fault_next  = (state_next == ST_FAULT);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_act
        assign act_next[gi] = (state_next == ST_ACT) && (cls_next == op_class_e'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cls_reg    <= CLS_ILL;
            ir_reg     <= '0;
            wd_reg     <= '0;
            opcode_reg <= '0;
            param1_reg <= '0;
            param2_reg <= '0;
            fcode_reg  <= FC_NONE;
            act_reg    <= '0;
            pc_reg     <= 1'b0;
            rd_reg     <= 1'b0;
            latch_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cls_reg    <= cls_next;
            ir_reg     <= ir_next;
            wd_reg     <= wd_next;
            opcode_reg <= opcode_next;
            param1_reg <= param1_next;
            param2_reg <= param2_next;
            fcode_reg  <= fcode_next;
            act_reg    <= act_next;
            pc_reg     <= pc_next;
            rd_reg     <= rd_next;
            latch_reg  <= latch_next;
            busy_reg   <= busy_next;
            halted_reg <= halted_next;
            fault_reg  <= fault_next;
        end
    end

    assign pcOut     = pc_reg;
    assign memRd     = rd_reg;
    assign irLatch   = latch_reg;
    assign opcode    = opcode_reg;
    assign param1    = param1_reg;
    assign param2    = param2_reg;
    assign aluAct    = act_reg[0];
    assign ldAct     = act_reg[1];
    assign movAct    = act_reg[2];
    assign jmpAct    = act_reg[3];
    assign busy      = busy_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;
    assign faultCode = fcode_reg;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed bench for instr_dispatch_fsm: a decode vector table plus hand-written
// multi-cycle sequences (done timing, stale done, timeout, halt, mid-op reset).
module tb_instr_dispatch_fsm;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] irIn;
    logic        aluDone, ldDone, movDone, jmpDone;
    logic        pcOut, memRd, irLatch;
    logic [3:0]  opcode;
    logic [5:0]  param1, param2;
    logic        aluAct, ldAct, movAct, jmpAct;
    logic        busy, halted, fault;
    logic [1:0]  faultCode;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    instr_dispatch_fsm #(.IR_W(16), .TIMEOUT(32), .TO_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .irIn(irIn),
        .aluDone(aluDone), .ldDone(ldDone), .movDone(movDone), .jmpDone(jmpDone),
        .pcOut(pcOut), .memRd(memRd), .irLatch(irLatch),
        .opcode(opcode), .param1(param1), .param2(param2),
        .aluAct(aluAct), .ldAct(ldAct), .movAct(movAct), .jmpAct(jmpAct),
        .busy(busy), .halted(halted), .fault(fault), .faultCode(faultCode)
    );

    // Packed view: {acts alu,ld,mov,jmp}[24:21] opcode[20:17] p1[16:11] p2[10:5] busy halted fault fcode[1:0]
    typedef struct {
        logic [15:0] ir;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [24:0] mk(input logic [3:0] act, input logic [3:0] opc,
                                       input logic [5:0] p1, input logic [5:0] p2,
                                       input logic bsy, input logic hlt,
                                       input logic flt, input logic [1:0] fc);
        return {act, opc, p1, p2, bsy, hlt, flt, fc};
    endfunction

    function automatic logic [24:0] obs();
        return {aluAct, ldAct, movAct, jmpAct, opcode, param1, param2,
                busy, halted, fault, faultCode};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    logic strobe_seen;
    logic halt_held;

    initial begin
        rst = 1'b0; start = 1'b0; irIn = '0;
        aluDone = 1'b0; ldDone = 1'b0; movDone = 1'b0; jmpDone = 1'b0;
        step(2);

        vecs[0] = '{16'h0123, mk(4'b1000, 4'h0, 6'd4,  6'd35, 1, 0, 0, 2'd0)};
        vecs[1] = '{16'h7FFF, mk(4'b1000, 4'h7, 6'd63, 6'd63, 1, 0, 0, 2'd0)};
        vecs[2] = '{16'h8000, mk(4'b0100, 4'h8, 6'd0,  6'd0,  1, 0, 0, 2'd0)};
        vecs[3] = '{16'h9041, mk(4'b0010, 4'h9, 6'd1,  6'd1,  1, 0, 0, 2'd0)};
        vecs[4] = '{16'hA5C3, mk(4'b0001, 4'hA, 6'd23, 6'd3,  1, 0, 0, 2'd0)};
        vecs[5] = '{16'hB000, mk(4'b0000, 4'hB, 6'd0,  6'd0,  0, 0, 1, 2'd1)};
        vecs[6] = '{16'hE7C0, mk(4'b0000, 4'hE, 6'd31, 6'd0,  0, 0, 1, 2'd1)};
        vecs[7] = '{16'hF000, mk(4'b0000, 4'hF, 6'd0,  6'd0,  0, 1, 0, 2'd0)};

        // Decode table: strobes in FETCH1, then full output set 4 cycles after start.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            irIn  = vecs[i].ir;
            start = 1'b1;
            step(2);
            check($sformatf("fetch1_strobes_%04h", vecs[i].ir),
                  32'({pcOut, memRd, irLatch}), 32'b111);
            step(2);
            check($sformatf("decode_%04h", vecs[i].ir), 32'(obs()), 32'(vecs[i].exp));
            start = 1'b0;
        end

        // Reset state, then ALU instruction with done 9 cycles after the activate.
        do_reset();
        check("reset_outputs", 32'({obs(), pcOut, memRd, irLatch}), 32'd0);
        irIn  = 16'h0123;
        start = 1'b1;
        step(3);
        check("no_act_in_decode", 32'({aluAct, ldAct, movAct, jmpAct}), 32'd0);
        step(1);
        check("alu_act_pulse", 32'(obs()), 32'(mk(4'b1000, 4'h0, 6'd4, 6'd35, 1, 0, 0, 2'd0)));
        start = 1'b0;
        step(1);
        check("alu_act_single", 32'({aluAct, ldAct, movAct, jmpAct}), 32'd0);
        step(8);
        aluDone = 1'b1;
        check("no_fetch_before_done", 32'(memRd), 32'd0);
        step(1);
        check("fetch0_after_done", 32'({pcOut, memRd, irLatch}), 32'b110);

        // Stale done held high through ACT must not end the next WAIT.
        step(3);
        check("second_alu_act", 32'(aluAct), 32'd1);
        step(1);
        check("stale_done_ignored", 32'({busy, memRd, aluAct}), 32'b100);
        aluDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("wait_hold_%0d", i), 32'(memRd), 32'd0);
        end
        aluDone = 1'b1;
        step(1);
        check("fetch_after_fresh_done", 32'({pcOut, memRd}), 32'b11);
        aluDone = 1'b0;

        // LDI with only a foreign done high: watchdog fault after 32 WAIT cycles.
        do_reset();
        irIn    = 16'h8000;
        jmpDone = 1'b1;
        start   = 1'b1;
        step(4);
        check("ldi_act", 32'(ldAct), 32'd1);
        start = 1'b0;
        step(32);
        check("wait_cycle_32", 32'({busy, fault}), 32'b10);
        step(1);
        check("timeout_fault", 32'(obs()), 32'(mk(4'b0000, 4'h8, 6'd0, 6'd0, 0, 0, 1, 2'd2)));
        strobe_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            strobe_seen |= memRd;
        end
        check("no_memrd_after_timeout", 32'({strobe_seen, fault, faultCode}), 32'b0110);
        jmpDone = 1'b0;

        // Illegal opcode is sticky even with start held.
        do_reset();
        irIn  = 16'hB000;
        start = 1'b1;
        step(4);
        strobe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            strobe_seen |= memRd;
        end
        check("illegal_sticky", 32'({strobe_seen, obs()}),
              32'({1'b0, mk(4'b0000, 4'hB, 6'd0, 6'd0, 0, 0, 1, 2'd1)}));

        // HALT with start held: no fetch for 20 cycles, rst clears everything.
        do_reset();
        irIn  = 16'hF000;
        start = 1'b1;
        step(4);
        strobe_seen = 1'b0;
        halt_held   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            strobe_seen |= memRd;
            halt_held   &= halted;
        end
        check("halt_sticky", 32'({strobe_seen, halt_held}), 32'b01);
        start = 1'b0;
        do_reset();
        check("reset_from_halt", 32'({obs(), pcOut, memRd, irLatch}), 32'd0);

        // Reset during MOV WAIT, then a clean refetch.
        irIn  = 16'h9041;
        start = 1'b1;
        step(4);
        check("mov_act", 32'(movAct), 32'd1);
        start = 1'b0;
        step(3);
        do_reset();
        check("reset_mid_wait", 32'({obs(), pcOut, memRd, irLatch}), 32'd0);
        step(2);
        check("idle_without_start", 32'({busy, memRd}), 32'd0);
        start = 1'b1;
        step(4);
        check("mov_refetch", 32'(obs()), 32'(mk(4'b0010, 4'h9, 6'd1, 6'd1, 1, 0, 0, 2'd0)));
        start   = 1'b0;
        movDone = 1'b1;
        step(1);
        check("mov_wait_entered", 32'({busy, memRd}), 32'b10);
        step(1);
        check("mov_done_fetch", 32'({pcOut, memRd}), 32'b11);
        movDone = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
